reg_wb_queue: RTL

REG_WB_QUEUE -- requirements
Module: reg_wb_queue

---
 rtl/reg_wb_queue_if.sv | 30 +++
 rtl/reg_wb_queue.sv | 81 ++++++++
 2 files changed

// File: rtl/reg_wb_queue_if.sv
// Bundle for the register write-back queue: write request handshake,
// drain hold, registered read port and status.
interface reg_wb_queue_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  // A request is taken on a rising edge where wr_valid && wr_ready. wr_ready
  // comes only from registered state, so a master may drive wr_valid from it.
  logic             wr_valid;
  logic             wr_ready;
  logic [3:0]       wr_idx;
  logic [WIDTH-1:0] wr_data;
  logic             wb_hold;
  logic [3:0]       rd_idx;
  logic [WIDTH-1:0] rd_val;
  logic [CW-1:0]    count;
  logic             err;

  modport master (
    output wr_valid, wr_idx, wr_data, wb_hold, rd_idx,
    input  wr_ready, rd_val, count, err
  );

  modport slave (
    input  wr_valid, wr_idx, wr_data, wb_hold, rd_idx,
    output wr_ready, rd_val, count, err
  );
endinterface

// File: rtl/reg_wb_queue.sv
// Register array fronted by a small FIFO of pending writes. Reads see the
// youngest pending write to the same register before it reaches the array.
module reg_wb_queue #(
  parameter int NREGS = 10,
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  reg_wb_queue_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [4:0] NREGS_W = 5'(NREGS);

  logic [WIDTH-1:0] r_arr    [NREGS];
  logic [3:0]       r_q_idx  [DEPTH];
  logic [WIDTH-1:0] r_q_data [DEPTH];
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [PW:0]      r_count;
  logic             r_err;
  logic [WIDTH-1:0] r_rd_val;

  logic             w_ready;
  logic             w_accept;
  logic             w_wr_ok;
  logic             w_push;
  logic             w_pop;
  logic             w_rd_ok;
  logic [WIDTH-1:0] w_rd_next;

  // count never exceeds DEPTH (a power of two), so its top bit means full.
  assign w_ready  = ~r_count[PW];
  assign w_accept = bus.wr_valid & w_ready;
  assign w_wr_ok  = {1'b0, bus.wr_idx} < NREGS_W;
  assign w_push   = w_accept & w_wr_ok;
  assign w_pop    = (r_count != '0) & ~bus.wb_hold;
  assign w_rd_ok  = {1'b0, bus.rd_idx} < NREGS_W;

  // Walk oldest to youngest so the last match wins; the head entry being
  // popped this edge is still part of the pre-edge queue.
  always_comb begin
    w_rd_next = '0;
    if (w_rd_ok) begin
      w_rd_next = r_arr[bus.rd_idx];
      for (int k = 0; k < DEPTH; k++) begin
        if (((PW+1)'(k) < r_count) && (r_q_idx[r_head + PW'(k)] == bus.rd_idx))
          w_rd_next = r_q_data[r_head + PW'(k)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
      r_rd_val <= '0;
      for (int i = 0; i < NREGS; i++) r_arr[i] <= '0;
    end else begin
      if (w_push) begin
        r_q_idx[r_tail]  <= bus.wr_idx;
        r_q_data[r_tail] <= bus.wr_data;
        r_tail           <= r_tail + PW'(1);
      end
      if (w_accept && !w_wr_ok) r_err <= 1'b1;
      if (w_pop) begin
        r_arr[r_q_idx[r_head]] <= r_q_data[r_head];
        r_head                 <= r_head + PW'(1);
      end
      r_count  <= r_count + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};
      r_rd_val <= w_rd_next;
    end
  end

  assign bus.wr_ready = w_ready;
  assign bus.rd_val   = r_rd_val;
  assign bus.count    = r_count;
  assign bus.err      = r_err;
endmodule
